// File: rtl/button_peripheral.sv
// -----------------------------------------------------------------------------
// button_peripheral
//   Memory-mapped input block. External buttons/switches are synchronised,
//   debounced per bit, and rising edges of the debounced level are latched
//   into sticky pending flags that can raise a masked level interrupt.
//
//   Register map (addr_i[3:2]):
//     0x0 STABLE   RO  debounced levels
//     0x4 PENDING  W1C sticky rising-edge flags
//     0x8 IRQ_EN   RW  interrupt mask
//     0xC RAW      RO  synchroniser output
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     rd_en_i, wr_en_i    bus read / write strobes
//     addr_i, data_i      byte address (only [3:2] decoded), write data
//     data_o              read data, combinational, 0 when rd_en_i = 0
//     btn_i               raw asynchronous inputs
//     irq_o               OR of (pending & irq_en)
// -----------------------------------------------------------------------------
module button_peripheral #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en_i,
    input  logic             wr_en_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [WIDTH-1:0] btn_i,
    output logic             irq_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Acceptance happens on the edge where the count would reach
    // DEBOUNCE_CYCLES, i.e. when it currently holds DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ADDR_STABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_IRQ_EN  = 2'd2;
    localparam logic [1:0] ADDR_RAW     = 2'd3;

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [CW-1:0]    cnt_r     [WIDTH];
    logic [CW-1:0]    cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] stable_nxt_s;
    logic [WIDTH-1:0] pending_r;
    logic [WIDTH-1:0] pending_nxt_s;
    logic [WIDTH-1:0] irq_en_r;
    logic [WIDTH-1:0] w1c_s;
    logic [31:0]      rd_word_s;
    logic             unused_s;

    assign raw_s = sync_r[SYNC_STAGES-1];

    // Upper address bits and unused write-data bits are intentionally ignored.
    assign unused_s = ^{addr_i[31:4], addr_i[1:0], data_i};

    // Input synchroniser: SYNC_STAGES flops per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
        end else begin
            sync_r[0] <= btn_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Per-bit debounce: count consecutive mismatches, accept on the last one.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (raw_s[i] == stable_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_nxt_s[i] = raw_s[i];
                cnt_nxt_s[i]    = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Pending update: W1C first, then a new rising edge sets (set wins).
    always_comb begin
        w1c_s = '0;
        if (wr_en_i && (addr_i[3:2] == ADDR_PENDING)) begin
            w1c_s = data_i[WIDTH-1:0];
        end else begin
            w1c_s = '0;
        end
        pending_nxt_s = (pending_r & ~w1c_s) | (stable_nxt_s & ~stable_r);
    end

    // Debounce counters, stable levels, pending flags and interrupt mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
            stable_r  <= '0;
            pending_r <= '0;
            irq_en_r  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            stable_r  <= stable_nxt_s;
            pending_r <= pending_nxt_s;
            if (wr_en_i && (addr_i[3:2] == ADDR_IRQ_EN)) begin
                irq_en_r <= data_i[WIDTH-1:0];
            end else begin
                irq_en_r <= irq_en_r;
            end
        end
    end

    // Read mux: reflects register contents before any same-cycle write.
    always_comb begin
        rd_word_s = 32'd0;
        if (rd_en_i) begin
            case (addr_i[3:2])
                ADDR_STABLE:  rd_word_s[WIDTH-1:0] = stable_r;
                ADDR_PENDING: rd_word_s[WIDTH-1:0] = pending_r;
                ADDR_IRQ_EN:  rd_word_s[WIDTH-1:0] = irq_en_r;
                ADDR_RAW:     rd_word_s[WIDTH-1:0] = raw_s;
                default:      rd_word_s = 32'd0;
            endcase
        end else begin
            rd_word_s = 32'd0;
        end
    end

    assign data_o = rd_word_s;
    assign irq_o  = |(pending_r & irq_en_r);

endmodule

// File: tb/tb_button_peripheral.sv
// -----------------------------------------------------------------------------
// tb_button_peripheral
//   Self-checking bench for button_peripheral (WIDTH=8, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=16). A reference model keeps the input history in queues:
//   a bit's debounced level flips once the last DEBOUNCE_CYCLES synchronised
//   samples all disagree with it. Directed sequences, a table of bus
//   vectors and a randomized phase are all compared against it.
// -----------------------------------------------------------------------------
module tb_button_peripheral;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   data_o;
    logic [W-1:0]  btn;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [W-1:0] sync_q[$];
    logic [W-1:0] win_q[$];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_pending;
    logic [W-1:0] m_irq_en;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } bus_vec_t;

    bus_vec_t vecs[14];

    button_peripheral #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en_i(rd_en), .wr_en_i(wr_en),
        .addr_i(addr), .data_i(wdata), .data_o(data_o),
        .btn_i(btn), .irq_o(irq)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sync_q.delete();
        win_q.delete();
        for (int i = 0; i < S; i++) sync_q.push_back('0);
        for (int i = 0; i < D; i++) win_q.push_back('0);
        m_stable  = '0;
        m_pending = '0;
        m_irq_en  = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [W-1:0] raw_prev, new_st, clr;
        bit all_diff;
        if (rst_n !== 1'b1) return;
        raw_prev = sync_q[S-1];
        sync_q.push_front(btn);
        void'(sync_q.pop_back());
        win_q.push_front(raw_prev);
        void'(win_q.pop_back());
        new_st = m_stable;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            foreach (win_q[k]) if (win_q[k][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) new_st[i] = ~m_stable[i];
        end
        clr = (wr_en && addr[3:2] == 2'd1) ? wdata[W-1:0] : '0;
        m_pending = (m_pending & ~clr) | (new_st & ~m_stable);
        if (wr_en && addr[3:2] == 2'd2) m_irq_en = wdata[W-1:0];
        m_stable = new_st;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: v[W-1:0] = m_stable;
            2'd1: v[W-1:0] = m_pending;
            2'd2: v[W-1:0] = m_irq_en;
            default: v[W-1:0] = sync_q[S-1];
        endcase
        return v;
    endfunction

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        rd_en = 1'b1;
        addr  = a;
        #1;
        v = data_o;
        rd_en = 1'b0;
    endtask

    // Compare every register and irq_o with the model (random upper address bits).
    task automatic check_all();
        logic [31:0] v;
        for (int a = 0; a < 4; a++) begin
            rd(($urandom() & 32'hFFFF_FFF0) | (32'(a) << 2), v);
            check($sformatf("model reg%0d", a), v, model_read(2'(a)));
        end
        check("model irq", {31'd0, irq}, {31'd0, |(m_pending & m_irq_en)});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        rd_en = 1'b0;
        addr  = a;
        wdata = d;
        tick();
    endtask

    task automatic do_reset(input logic [W-1:0] b, input int cycles);
        rst_n = 1'b0;
        btn   = b;
        model_reset();
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        rst_n = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        btn   = 8'hFF;
        model_reset();

        // ---------------- reset with inputs held high ----------------
        #2;
        rd(32'h0, v);  check("reset STABLE", v, 32'h0);
        rd(32'hC, v);  check("reset RAW", v, 32'h0);
        check("reset irq", {31'd0, irq}, 32'd0);
        do_reset(8'hFF, 3);
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (n == 2) begin rd(32'hC, v); check("post-reset RAW", v, 32'hFF); end
            if (n == 17) begin rd(32'h0, v); check("post-reset STABLE@17", v, 32'h0); end
        end
        rd(32'h0, v); check("post-reset STABLE@18", v, 32'hFF);
        rd(32'h4, v); check("post-reset PENDING", v, 32'hFF);

        // ---------------- bus rules table ----------------
        do_reset(8'h00, 2);
        for (int i = 0; i < 4; i++) tick();
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_00A5, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hA5};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_003C, 32'hA5};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h3C};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h3C};
        vecs[10] = '{1'b0, 1'b1, 32'h1230_0008, 32'hFFFF_FF5A, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h5A};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0};
        for (int i = 0; i < 14; i++) begin
            rd_en = vecs[i].rd;
            wr_en = vecs[i].wr;
            addr  = vecs[i].addr;
            wdata = vecs[i].data;
            #1;
            check($sformatf("bus vec%0d", i), data_o, vecs[i].exp);
            tick();
        end

        // ---------------- clean press on bit 3 ----------------
        btn = 8'h08;
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (n == 1) begin rd(32'hC, v); check("press RAW@1", v, 32'h00); end
            if (n == 2) begin rd(32'hC, v); check("press RAW@2", v, 32'h08); end
            if (n == 17) begin rd(32'h0, v); check("press STABLE@17", v, 32'h00); end
        end
        rd(32'h0, v); check("press STABLE@18", v, 32'h08);
        rd(32'h4, v); check("press PENDING", v, 32'h08);
        wr(32'h4, 32'h08);
        rd(32'h4, v); check("W1C PENDING", v, 32'h00);
        rd(32'h0, v); check("W1C STABLE", v, 32'h08);

        // ---------------- bounce on bit 0 ----------------
        for (int k = 0; k < 12; k++) begin
            btn[0] = (k % 2 == 0);
            for (int c = 0; c < 5; c++) begin
                tick();
                rd(32'h0, v); check("bounce STABLE0", {31'd0, v[0]}, 32'd0);
                rd(32'h4, v); check("bounce PENDING0", {31'd0, v[0]}, 32'd0);
            end
        end
        btn[0] = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (n == 17) begin rd(32'h0, v); check("settle STABLE@17", v, 32'h08); end
        end
        rd(32'h0, v); check("settle STABLE@18", v, 32'h09);
        rd(32'h4, v); check("settle PENDING", v, 32'h01);
        wr(32'h4, 32'h01);
        for (int n = 0; n < 20; n++) tick();
        rd(32'h4, v); check("settle no re-set", v, 32'h00);

        // ---------------- interrupt ----------------
        wr(32'h8, 32'h04);
        btn = btn | 8'h04;
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (n == 17) check("irq@17", {31'd0, irq}, 32'd0);
        end
        check("irq@18", {31'd0, irq}, 32'd1);
        wr(32'h4, 32'h04);
        check("irq after W1C", {31'd0, irq}, 32'd0);
        btn = btn | 8'h20;
        for (int n = 0; n < 20; n++) tick();
        check("irq masked bit5", {31'd0, irq}, 32'd0);
        rd(32'h4, v); check("bit5 pending", v, 32'h20);

        // ---------------- simultaneous set and W1C ----------------
        btn = btn | 8'h02;
        for (int n = 1; n <= 17; n++) tick();
        wr(32'h4, 32'h22);
        rd(32'h4, v); check("set beats W1C", v, 32'h02);

        // ---------------- randomized phase with a mid-run reset ----------------
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset(btn, 3);
            if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, W-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                wr_en = 1'b1;
                rd_en = 1'($urandom_range(0, 1));
                addr  = $urandom();
                wdata = $urandom();
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
